axi_bin_to_onehot_queue: RTL and testbench
==========================================

// Module: axi_bin_to_onehot_queue
// PURPOSE
//  Ordered queue of binary port indices with one-hot decoded output, the inverse of the
//  one-hot-to-binary encode step. The request side pushes the binary target/source index of each
//  issued transaction. The response side pops entries in order and gets a one-hot select
//  for the response mux/demux. Sits between the request arbiter and the response router.
// PARAMETERS
//  ONEHOT_WIDTH  16                        number of ports, width of one-hot select
//  BIN_WIDTH     `log2(ONEHOT_WIDTH-1)     width of binary index (defines.v macro)
//  DEPTH         4                         max outstanding entries, >=2, need not be pow2
//  PTR_WIDTH     `log2(DEPTH-1)            read/write pointer width
//  CNT_WIDTH     `log2(DEPTH)              occupancy counter width (holds 0..DEPTH)
// PORTS
//  clk           in   1             clock, all state on rising edge
//  rst           in   1             asynchronous, active-high reset
//  flush_i       in   1             synchronous clear of all entries
//  push_valid_i  in   1             push request
//  push_ready_o  out  1             queue can accept (= not full)
//  push_bin_i    in   BIN_WIDTH     binary index to enqueue
//  pop_valid_o   out  1             head entry available (= not empty)
//  pop_ready_i   in   1             consumer takes head this cycle
//  pop_onehot_o  out  ONEHOT_WIDTH  one-hot decode of head index
//  pop_bin_o     out  BIN_WIDTH     head index, raw
//  pop_err_o     out  1             head index >= ONEHOT_WIDTH (out of range)
//  count_o       out  CNT_WIDTH     current occupancy
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0. Therefore push_ready_o=1,
//    pop_valid_o=0, pop_onehot_o=0, pop_bin_o=0, pop_err_o=0, count_o=0.
//    Storage array is not reset.
//  - Push fires on push_valid_i & push_ready_o. The entry is written at wr_ptr.
//    wr_ptr wraps from DEPTH-1 to 0.
//  - Pop fires on pop_valid_o & pop_ready_i. rd_ptr wraps from DEPTH-1 to 0.
//  - Latency is 1 cycle, with no fall-through. An entry pushed in cycle N is visible on pop_* from
//    cycle N+1.
//  - push_ready_o = (count != DEPTH). It has no combinational dependency on pop_ready_i, so a
//    full queue refuses a push even when a pop fires in the same cycle.
//  - pop_valid_o = (count != 0). pop_valid_o, pop_onehot_o, pop_bin_o and pop_err_o depend only
//    on registered state, with no comb path from pop_ready_i.
//  - Simultaneous push and pop (not full, not empty): both pointers advance and count is
//    unchanged.
//  - pop_onehot_o[k] = pop_valid_o & (head == k). Exactly one bit is set when valid and in range.
//    It is all zero when empty or when pop_err_o=1.
//  - pop_err_o = pop_valid_o & (head >= ONEHOT_WIDTH). It only occurs when ONEHOT_WIDTH is not a
//    power of 2. The erroneous entry is still popped normally.
//  - pop_bin_o = head when valid, else 0.
//  - Pop with pop_valid_o=0 is ignored. Push with push_ready_o=0 is dropped, and the producer
//    must hold push_valid_i/push_bin_i stable until ready.
//  - flush_i: next cycle ptrs=0 and count=0. It has priority over a same-cycle push or pop, and
//    both are discarded.
//  - Reset asserted mid-operation clears immediately and asynchronously. Outputs reach reset
//    values without waiting for clk.
// STRUCTURE
//  - Shared package axi_onehot_pkg: width helper function clog2-equivalent, default DEPTH.
//  - Sub-module axi_bin_to_onehot: combinational decoder (bin -> onehot + out-of-range flag),
//    instanced once on the head entry. Queue control (pointers, counter) stays in this module.
// TESTING
//  1 Reset: assert rst mid-traffic with count=3 -> same cycle count_o=0, pop_valid_o=0,
//    pop_onehot_o=16'h0000, push_ready_o=1.
//  2 Order/decode: push 3,0,15 -> pops give onehot 16'h0008, 16'h0001, 16'h8000 in order,
//    pop_bin_o 3,0,15.
//  3 Full/wrap: DEPTH=3, push 5 entries with pop_ready_i=0 -> only 3 accepted, push_ready_o=0,
//    count_o=3. Drain, then push/pop 7 more -> pointer wrap, order preserved.
//  4 Simultaneous: count=2, push 9 and pop together for 4 cycles -> count_o stays 2.
//    When full, push with pop -> push refused.
//  5 Out of range: ONEHOT_WIDTH=5 (BIN_WIDTH=3), push 6 -> pop_err_o=1, pop_onehot_o=5'b00000.
//    The entry pops and the next in-range entry decodes correctly.
//  6 Flush: count=2, flush_i with push_valid_i=1 -> next cycle count_o=0, pop_valid_o=0,
//    the pushed value is never seen.

Source files
------------

// File: rtl/axi_onehot_pkg.sv
// Shared widths and helpers for the binary/one-hot port index queues.
package axi_onehot_pkg;

    localparam int DEFAULT_ONEHOT_WIDTH = 16;
    localparam int DEFAULT_DEPTH        = 4;

    // Bits needed to represent 'value' itself (e.g. 15 -> 4, 4 -> 3), minimum 1.
    function automatic int bits_for(input int value);
        int b;
        b = 1;
        while ((1 << b) <= value) b++;
        return b;
    endfunction

endpackage

// File: rtl/axi_bin_to_onehot.sv
// Combinational binary-to-one-hot decoder with an out-of-range flag.
module axi_bin_to_onehot #(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = 4
) (
    input  logic                    valid,
    input  logic [BIN_WIDTH-1:0]    bin,
    output logic [ONEHOT_WIDTH-1:0] onehot,
    output logic                    err
);

    localparam logic [BIN_WIDTH:0] LIMIT = (BIN_WIDTH+1)'(ONEHOT_WIDTH);

    always_comb begin
        onehot = '0;
        err    = valid && ({1'b0, bin} >= LIMIT);
        for (int k = 0; k < ONEHOT_WIDTH; k++) begin
            if (valid && (bin == BIN_WIDTH'(k))) onehot[k] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_bin_to_onehot_queue.sv
// In-order queue of binary port indices; the head is presented one-hot decoded.
module axi_bin_to_onehot_queue
    import axi_onehot_pkg::*;
#(
    parameter  int ONEHOT_WIDTH = DEFAULT_ONEHOT_WIDTH,
    parameter  int DEPTH        = DEFAULT_DEPTH,
    localparam int BIN_WIDTH    = bits_for(ONEHOT_WIDTH - 1),
    localparam int PTR_WIDTH    = bits_for(DEPTH - 1),
    localparam int CNT_WIDTH    = bits_for(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    push_valid_i,
    output logic                    push_ready_o,
    input  logic [BIN_WIDTH-1:0]    push_bin_i,
    output logic                    pop_valid_o,
    input  logic                    pop_ready_i,
    output logic [ONEHOT_WIDTH-1:0] pop_onehot_o,
    output logic [BIN_WIDTH-1:0]    pop_bin_o,
    output logic                    pop_err_o,
    output logic [CNT_WIDTH-1:0]    count_o
);

    logic [BIN_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 push_fire, pop_fire;
    logic [BIN_WIDTH-1:0] head;

    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    assign push_ready_o = (count != CNT_WIDTH'(DEPTH));
    assign pop_valid_o  = (count != '0);
    assign push_fire    = push_valid_i && push_ready_o;
    assign pop_fire     = pop_valid_o && pop_ready_i;
    assign count_o      = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= ptr_next(wr_ptr);
            if (pop_fire)  rd_ptr <= ptr_next(rd_ptr);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; empty slots are never observable on the outputs.
    always_ff @(posedge clk) begin
        if (push_fire && !flush_i) mem[wr_ptr] <= push_bin_i;
    end

    assign head      = mem[rd_ptr];
    assign pop_bin_o = pop_valid_o ? head : '0;

    axi_bin_to_onehot #(
        .ONEHOT_WIDTH (ONEHOT_WIDTH),
        .BIN_WIDTH    (BIN_WIDTH)
    ) u_dec (
        .valid  (pop_valid_o),
        .bin    (head),
        .onehot (pop_onehot_o),
        .err    (pop_err_o)
    );

endmodule

// File: tb/tb_axi_bin_to_onehot_queue.sv
// Bench: three queue configurations checked every cycle against a queue-based reference model.
module tb_axi_bin_to_onehot_queue;

    localparam int NI = 3;
    localparam int W [NI] = '{16, 16, 5};
    localparam int D [NI] = '{4, 3, 4};
    localparam int BW[NI] = '{4, 4, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pv  = '0;
    logic [2:0] pr  = '0;
    logic [2:0] fl  = '0;
    logic [3:0] pb [NI];

    wire  [2:0]  rdy, vld, err;
    wire  [3:0]  bin0, bin1;
    wire  [2:0]  bin2;
    wire  [15:0] oh0, oh1;
    wire  [4:0]  oh2;
    wire  [2:0]  cnt0, cnt2;
    wire  [1:0]  cnt1;

    int total = 0;
    int bad   = 0;
    int q [NI][$];

    always #5 clk = ~clk;

    axi_bin_to_onehot_queue #(.ONEHOT_WIDTH(16), .DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .flush_i(fl[0]), .push_valid_i(pv[0]), .push_ready_o(rdy[0]),
        .push_bin_i(pb[0]), .pop_valid_o(vld[0]), .pop_ready_i(pr[0]), .pop_onehot_o(oh0),
        .pop_bin_o(bin0), .pop_err_o(err[0]), .count_o(cnt0));

    axi_bin_to_onehot_queue #(.ONEHOT_WIDTH(16), .DEPTH(3)) u1 (
        .clk(clk), .rst(rst), .flush_i(fl[1]), .push_valid_i(pv[1]), .push_ready_o(rdy[1]),
        .push_bin_i(pb[1]), .pop_valid_o(vld[1]), .pop_ready_i(pr[1]), .pop_onehot_o(oh1),
        .pop_bin_o(bin1), .pop_err_o(err[1]), .count_o(cnt1));

    axi_bin_to_onehot_queue #(.ONEHOT_WIDTH(5), .DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .flush_i(fl[2]), .push_valid_i(pv[2]), .push_ready_o(rdy[2]),
        .push_bin_i(pb[2][2:0]), .pop_valid_o(vld[2]), .pop_ready_i(pr[2]), .pop_onehot_o(oh2),
        .pop_bin_o(bin2), .pop_err_o(err[2]), .count_o(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int n, head;
            logic ev;
            logic [31:0] eoh, ooh, obin, ocnt;
            n    = q[i].size();
            ev   = (n != 0);
            head = ev ? q[i][0] : 0;
            eoh  = (ev && head < W[i]) ? (32'd1 << head) : 32'd0;
            case (i)
                0:       begin ooh = 32'(oh0); obin = 32'(bin0); ocnt = 32'(cnt0); end
                1:       begin ooh = 32'(oh1); obin = 32'(bin1); ocnt = 32'(cnt1); end
                default: begin ooh = 32'(oh2); obin = 32'(bin2); ocnt = 32'(cnt2); end
            endcase
            chk($sformatf("u%0d count", i),  ocnt, 32'(n));
            chk($sformatf("u%0d valid", i),  32'(vld[i]), 32'(ev));
            chk($sformatf("u%0d ready", i),  32'(rdy[i]), 32'(n != D[i]));
            chk($sformatf("u%0d bin", i),    obin, 32'(head));
            chk($sformatf("u%0d onehot", i), ooh, eoh);
            chk($sformatf("u%0d err", i),    32'(err[i]), 32'(ev && head >= W[i]));
        end
    endtask

    task automatic update_model();
        for (int i = 0; i < NI; i++) begin
            int n;
            logic do_pop, do_push;
            if (fl[i]) begin
                q[i].delete();
            end else begin
                n       = q[i].size();
                do_pop  = (n != 0) && pr[i];
                do_push = pv[i] && (n != D[i]);
                if (do_pop) void'(q[i].pop_front());
                if (do_push) q[i].push_back(int'(pb[i]) % (1 << BW[i]));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle();
        pv = '0; pr = '0; fl = '0;
        for (int i = 0; i < NI; i++) pb[i] = '0;
    endtask

    task automatic drain(input int i);
        idle();
        pr[i] = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        pr[i] = 1'b0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // reset mid-traffic with three entries held
        pv[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin pb[0] = 4'(k + 1); tick(); end
        idle();
        chk("pre-reset count", 32'(cnt0), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst count", 32'(cnt0), 32'd0);
        chk("rst valid", 32'(vld[0]), 32'd0);
        chk("rst onehot", 32'(oh0), 32'h0000);
        chk("rst ready", 32'(rdy[0]), 32'd1);
        for (int i = 0; i < NI; i++) q[i].delete();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // order and decode
        pv[0] = 1'b1;
        pb[0] = 4'd3;  tick();
        pb[0] = 4'd0;  tick();
        pb[0] = 4'd15; tick();
        idle();
        pr[0] = 1'b1;
        chk("order oh 3", 32'(oh0), 32'h0008);  chk("order bin 3", 32'(bin0), 32'd3);
        tick();
        chk("order oh 0", 32'(oh0), 32'h0001);  chk("order bin 0", 32'(bin0), 32'd0);
        tick();
        chk("order oh 15", 32'(oh0), 32'h8000); chk("order bin 15", 32'(bin0), 32'd15);
        tick();
        chk("order empty", 32'(vld[0]), 32'd0);
        idle();

        // full and wrap on the depth-3 instance
        pv[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin pb[1] = 4'(k + 1); tick(); end
        chk("full ready", 32'(rdy[1]), 32'd0);
        chk("full count", 32'(cnt1), 32'd3);
        drain(1);
        pv[1] = 1'b1; pr[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin pb[1] = 4'(k + 8); tick(); end
        drain(1);
        chk("wrap drained", 32'(cnt1), 32'd0);

        // simultaneous push and pop
        pv[1] = 1'b1; pb[1] = 4'd4; tick(); tick();
        pb[1] = 4'd9; pr[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin tick(); chk("simul count", 32'(cnt1), 32'd2); end
        pr[1] = 1'b0; tick();
        chk("simul full", 32'(cnt1), 32'd3);
        pb[1] = 4'd12; pr[1] = 1'b1; tick();
        chk("full push refused", 32'(cnt1), 32'd2);
        drain(1);

        // out-of-range head on the 5-port instance
        pv[2] = 1'b1;
        pb[2] = 4'd6; tick();
        pb[2] = 4'd2; tick();
        idle();
        chk("oor err", 32'(err[2]), 32'd1);
        chk("oor onehot", 32'(oh2), 32'd0);
        chk("oor bin", 32'(bin2), 32'd6);
        pr[2] = 1'b1; tick();
        chk("after oor err", 32'(err[2]), 32'd0);
        chk("after oor onehot", 32'(oh2), 32'b00100);
        tick();
        idle();

        // flush beats a same-cycle push
        pv[0] = 1'b1; pb[0] = 4'd1; tick(); tick();
        fl[0] = 1'b1; pb[0] = 4'd7; tick();
        chk("flush count", 32'(cnt0), 32'd0);
        chk("flush valid", 32'(vld[0]), 32'd0);
        idle(); tick();
        chk("flush push lost", 32'(vld[0]), 32'd0);

        // randomized traffic on all instances
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NI; i++) begin
                pv[i] = ($urandom_range(0, 99) < 60);
                pr[i] = ($urandom_range(0, 99) < 50);
                fl[i] = ($urandom_range(0, 99) < 3);
                pb[i] = 4'($urandom_range(0, 15));
            end
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
